// File: rtl/fft_butterfly_unit.sv
// rtl/fft_butterfly_unit.sv - pipelined radix-2 DIT butterfly with Q8.8 complex multiplier

// Combinational complex multiplier, product taken as bits [N+Q-1:Q] of the raw 2N-bit result
module fft_cmul #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    output logic [N-1:0] p_re,
    output logic [N-1:0] p_im
);
    logic [2*N-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
    logic [2*N-1:0] rr, ii, ri, ir;
    logic [2*N-1:0] raw_re, raw_im;
    logic           unused_bits;

    // Sign-extend to 2N so the low 2N bits of each product are the exact signed product
    assign a_re_x = {{N{a_re[N-1]}}, a_re};
    assign a_im_x = {{N{a_im[N-1]}}, a_im};
    assign b_re_x = {{N{b_re[N-1]}}, b_re};
    assign b_im_x = {{N{b_im[N-1]}}, b_im};

    assign rr = a_re_x * b_re_x;
    assign ii = a_im_x * b_im_x;
    assign ri = a_re_x * b_im_x;
    assign ir = a_im_x * b_re_x;

    assign raw_re = rr - ii;
    assign raw_im = ri + ir;

    // Dropping the low Q bits floors toward -inf; dropping the high bits wraps
    assign p_re = raw_re[N+Q-1:Q];
    assign p_im = raw_im[N+Q-1:Q];

    assign unused_bits = ^{raw_re[2*N-1:N+Q], raw_re[Q-1:0], raw_im[2*N-1:N+Q], raw_im[Q-1:0]};
endmodule

// Butterfly: S1 capture, S2 product, S3 add/sub with scale or saturation
module fft_butterfly_unit #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    input  logic         scale,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x0_re,
    output logic [N-1:0] x0_im,
    output logic [N-1:0] x1_re,
    output logic [N-1:0] x1_im,
    output logic         ovf,
    input  logic         ovf_clr
);
    logic         en;
    logic         s1_valid, s1_scale;
    logic [N-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;
    logic         s2_valid, s2_scale;
    logic [N-1:0] s2_a_re, s2_a_im, s2_p_re, s2_p_im;
    logic [N-1:0] p_re, p_im;
    logic [N:0]   s_re, s_im, d_re, d_im;
    logic [N:0]   r0_re, r0_im, r1_re, r1_im;
    logic         sat_any;

    // Whole pipeline advances together; stalls only when the output is held
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    fft_cmul #(.N(N), .Q(Q)) u_cmul (
        .a_re (s1_b_re),
        .a_im (s1_b_im),
        .b_re (s1_w_re),
        .b_im (s1_w_im),
        .p_re (p_re),
        .p_im (p_im)
    );

    // Returns {saturated, value}: scaled values halve with floor, unscaled values clamp
    function automatic logic [N:0] finish(input logic [N:0] v, input logic sc);
        logic [N:0] r;
        if (sc)
            r = {1'b0, v[N:1]};
        else if (!v[N] && v[N-1])
            r = {1'b1, 1'b0, {(N-1){1'b1}}};
        else if (v[N] && !v[N-1])
            r = {1'b1, 1'b1, {(N-1){1'b0}}};
        else
            r = {1'b0, v[N-1:0]};
        return r;
    endfunction

    assign s_re = {s2_a_re[N-1], s2_a_re} + {s2_p_re[N-1], s2_p_re};
    assign s_im = {s2_a_im[N-1], s2_a_im} + {s2_p_im[N-1], s2_p_im};
    assign d_re = {s2_a_re[N-1], s2_a_re} - {s2_p_re[N-1], s2_p_re};
    assign d_im = {s2_a_im[N-1], s2_a_im} - {s2_p_im[N-1], s2_p_im};

    assign r0_re = finish(s_re, s2_scale);
    assign r0_im = finish(s_im, s2_scale);
    assign r1_re = finish(d_re, s2_scale);
    assign r1_im = finish(d_im, s2_scale);

    assign sat_any = s2_valid && (r0_re[N] || r0_im[N] || r1_re[N] || r1_im[N]);

    // S1: capture the transaction; a cycle without a transfer loads a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s1_w_re  <= '0;
            s1_w_im  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_scale <= scale;
            s1_a_re  <= a_re;
            s1_a_im  <= a_im;
            s1_b_re  <= b_re;
            s1_b_im  <= b_im;
            s1_w_re  <= w_re;
            s1_w_im  <= w_im;
        end
    end

    // S2: capture the product alongside the delayed A operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
            s2_p_re  <= '0;
            s2_p_im  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_scale <= s1_scale;
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
            s2_p_re  <= p_re;
            s2_p_im  <= p_im;
        end
    end

    // S3: capture the finished butterfly outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x0_re     <= '0;
            x0_im     <= '0;
            x1_re     <= '0;
            x1_im     <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            x0_re     <= r0_re[N-1:0];
            x0_im     <= r0_im[N-1:0];
            x1_re     <= r1_re[N-1:0];
            x1_im     <= r1_im[N-1:0];
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (en && sat_any)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
endmodule

// File: tb/tb_fft_butterfly_unit.sv
// tb/tb_fft_butterfly_unit.sv - self-checking bench for fft_butterfly_unit
module tb_fft_butterfly_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic        scale;
    logic        out_valid, out_ready;
    logic [15:0] x0_re, x0_im, x1_re, x1_im;
    logic        ovf, ovf_clr;

    typedef struct packed {
        logic [15:0] x0r;
        logic [15:0] x0i;
        logic [15:0] x1r;
        logic [15:0] x1i;
    } res_t;

    res_t        q[$];
    int          passed = 0;
    int          total  = 0;
    int          delivered = 0;
    bit          prev_stall = 0;
    logic [63:0] held;

    fft_butterfly_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference arithmetic on plain integers
    function automatic longint fdiv(input longint v, input longint d);
        return (v >= 0) ? v / d : -((-v + d - 1) / d);
    endfunction

    function automatic longint wrap16(input longint v);
        longint m;
        m = ((v % 65536) + 65536) % 65536;
        return (m >= 32768) ? m - 65536 : m;
    endfunction

    function automatic logic [15:0] fin(input longint v, input bit sc);
        longint r;
        if (sc)              r = fdiv(v, 2);
        else if (v > 32767)  r = 32767;
        else if (v < -32768) r = -32768;
        else                 r = v;
        return 16'(r);
    endfunction

    function automatic res_t model(input logic [15:0] ar, ai, br, bi, wr, wi, input bit sc);
        longint a_r, a_i, b_r, b_i, w_r, w_i, p_r, p_i;
        res_t   r;
        a_r = longint'($signed(ar)); a_i = longint'($signed(ai));
        b_r = longint'($signed(br)); b_i = longint'($signed(bi));
        w_r = longint'($signed(wr)); w_i = longint'($signed(wi));
        p_r = wrap16(fdiv(b_r * w_r - b_i * w_i, 256));
        p_i = wrap16(fdiv(b_r * w_i + b_i * w_r, 256));
        r.x0r = fin(a_r + p_r, sc);
        r.x0i = fin(a_i + p_i, sc);
        r.x1r = fin(a_r - p_r, sc);
        r.x1i = fin(a_i - p_i, sc);
        return r;
    endfunction

    // Scoreboard: predict transfers at the negedge before the edge that performs them
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {x0_re, x0_im, x1_re, x1_im}, held);
            if (out_valid && q.size() == 0) begin
                check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                check("x0_re", {48'd0, x0_re}, {48'd0, e.x0r});
                check("x0_im", {48'd0, x0_im}, {48'd0, e.x0i});
                check("x1_re", {48'd0, x1_re}, {48'd0, e.x1r});
                check("x1_im", {48'd0, x1_im}, {48'd0, e.x1i});
                delivered++;
            end
            prev_stall = out_valid && !out_ready;
            held = {x0_re, x0_im, x1_re, x1_im};
            if (in_valid && in_ready)
                q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, scale));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a transaction and return just after the edge that accepts it; in_valid stays high
    task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc);
        logic ok;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi; scale = sc;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!out_valid) check("out_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        int cyc;
        int n;
        int base_del;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; scale = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        #12;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        check("rst_data",      {x0_re, x0_im, x1_re, x1_im}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Identity; handshake cycle c, out_valid in cycle c+3 (two edges after the accepting edge)
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        idle();
        wait_out(cyc);
        check("id_latency", 64'(cyc), 64'd2);
        check("id_out", {x0_re, x0_im, x1_re, x1_im}, {16'h0200, 16'h0000, 16'h0000, 16'h0000});
        check("id_ovf", {63'd0, ovf}, 64'd0);
        tick();

        // Rotation by -j
        send(16'h0080, 16'h0080, 16'h0100, 16'h0200, 16'h0000, 16'hFF00, 1'b0);
        idle();
        wait_out(cyc);
        check("rot_out", {x0_re, x0_im, x1_re, x1_im}, {16'h0280, 16'hFF80, 16'hFE80, 16'h0180});
        tick();

        // Saturation, then the same operands scaled
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        idle();
        wait_out(cyc);
        check("sat_x0_re", {48'd0, x0_re}, {48'd0, 16'h7FFF});
        check("sat_x1_re", {48'd0, x1_re}, 64'd0);
        check("sat_ovf", {63'd0, ovf}, 64'd1);
        for (int i = 0; i < 3; i++) tick();
        check("ovf_sticky", {63'd0, ovf}, 64'd1);
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h0100, 16'h0000, 1'b1);
        idle();
        wait_out(cyc);
        check("scale_x0_re", {48'd0, x0_re}, {48'd0, 16'h7000});
        check("scale_ovf_kept", {63'd0, ovf}, 64'd1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {63'd0, ovf}, 64'd0);

        // Truncation toward -inf
        send(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'hFF80, 16'h0000, 1'b0);
        idle();
        wait_out(cyc);
        check("trunc_x0_re", {48'd0, x0_re}, {48'd0, 16'hFFFF});
        check("trunc_x1_re", {48'd0, x1_re}, {48'd0, 16'h0001});
        tick();

        // Random traffic with random gaps and backpressure
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            a_re = 16'($urandom); a_im = 16'($urandom);
            b_re = 16'($urandom); b_im = 16'($urandom);
            w_re = 16'($urandom); w_im = 16'($urandom);
            scale = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rand_drained", 64'(q.size()), 64'd0);

        // Eight back-to-back transactions with a 5-cycle output stall mid-stream
        base_del = delivered;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            out_ready = !(i >= 4 && i < 9);
            in_valid  = (n < 8);
            a_re = 16'h0100 + 16'(n); a_im = 16'h0010;
            b_re = 16'h0040; b_im = 16'h0020; w_re = 16'h0100; w_im = 16'h0000;
            scale = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready)
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            if (acc) n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_delivered", 64'(delivered - base_del), 64'd8);
        check("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset with three transactions in flight
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        send(16'h0011, 16'h0022, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        send(16'h0033, 16'h0044, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        idle();
        check("pre_rst_ovf", {63'd0, ovf}, 64'd1);
        rst_n = 1'b0;
        #1;
        q.delete();
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
        check("mid_rst_data", {x0_re, x0_im, x1_re, x1_im}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale", {63'd0, out_valid}, 64'd0);
        end
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0);
        idle();
        wait_out(cyc);
        check("rec_latency", 64'(cyc), 64'd2);
        check("rec_out", {x0_re, x0_im, x1_re, x1_im}, {16'h0200, 16'h0000, 16'h0000, 16'h0000});
        for (int i = 0; i < 3; i++) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
